// File: rtl/alu_mc_if.sv
// Request/response bundle for alu_mc: request handshake, operands, registered result.
interface alu_mc_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [4:0]       aluc;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             z;
    logic             busy;

    modport master (
        output in_valid, a, b, aluc, out_ready,
        input  in_ready, out_valid, s, z, busy
    );

    modport slave (
        input  in_valid, a, b, aluc, out_ready,
        output in_ready, out_valid, s, z, busy
    );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops plus optional iterative mul/div.
// Define ALU_MC_MULDIV_EN to build the shift-add multiplier and restoring divider.
module alu_mc #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input logic     clock,
    input logic     reset,
    alu_mc_if.slave bus
);
    logic [WIDTH-1:0] res;
    logic             res_zero;
    logic             valid;
    logic [WIDTH-1:0] sc_res;
    logic [SHW-1:0]   sh;
    logic             accept;

    function automatic logic [WIDTH-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) c = c + {{(WIDTH - 1){1'b0}}, v[i]};
        return c;
    endfunction

    assign sh = bus.a[SHW-1:0];

    always_comb begin
        sc_res = '0;
        if (!bus.aluc[4]) begin
            casez (bus.aluc[3:0])
                4'b?000: sc_res = bus.a + bus.b;
                4'b?100: sc_res = bus.a - bus.b;
                4'b?001: sc_res = bus.a & bus.b;
                4'b?101: sc_res = bus.a | bus.b;
                4'b?010: sc_res = bus.a ^ bus.b;
                4'b?110: sc_res = bus.a << (WIDTH / 2);
                4'b0011: sc_res = bus.b << sh;
                4'b0111: sc_res = bus.b >> sh;
                4'b1111: sc_res = $unsigned($signed(bus.b) >>> sh);
                4'b1011: sc_res = popcount(bus.a ^ bus.b);
                default: sc_res = '0;
            endcase
        end
    end

    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.s         = res;
    assign bus.z         = res_zero;
    assign bus.out_valid = valid;

`ifdef ALU_MC_MULDIV_EN
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ITER = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [SHW-1:0]   cnt;
    logic [WIDTH:0]   acc;   // mul: running high half; div: partial remainder
    logic [WIDTH-1:0] lo;    // mul: multiplier / low product; div: dividend / quotient
    logic [WIDTH-1:0] opnd;
    logic             is_div;
    logic             want_hi;
    logic             is_md;
    logic [WIDTH:0]   msum;
    logic [WIDTH:0]   trial;
    logic             ge;
    logic [WIDTH-1:0] md_res;

    assign is_md    = bus.aluc[4] && (bus.aluc[3:2] == 2'b00);
    assign bus.in_ready = (state == IDLE) && (!valid || bus.out_ready);
    assign bus.busy = (state != IDLE);

    always_comb begin
        msum   = {1'b0, acc[WIDTH-1:0]} + (lo[0] ? {1'b0, opnd} : '0);
        trial  = {acc[WIDTH-1:0], lo[WIDTH-1]};
        ge     = trial >= {1'b0, opnd};
        md_res = want_hi ? acc[WIDTH-1:0] : lo;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            valid    <= 1'b0;
            res      <= '0;
            res_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && is_md) begin
                        state   <= ITER;
                        cnt     <= '0;
                        valid   <= 1'b0;
                        is_div  <= bus.aluc[1];
                        want_hi <= bus.aluc[0];
                        acc     <= '0;
                        opnd    <= bus.aluc[1] ? bus.b : bus.a;
                        lo      <= bus.aluc[1] ? bus.a : bus.b;
                    end else if (accept) begin
                        res      <= sc_res;
                        res_zero <= (sc_res == '0);
                        valid    <= 1'b1;
                    end else if (bus.out_ready) begin
                        valid <= 1'b0;
                    end
                end
                ITER: begin
                    if (is_div) begin
                        acc <= ge ? (trial - {1'b0, opnd}) : trial;
                        lo  <= {lo[WIDTH-2:0], ge};
                    end else begin
                        acc <= {1'b0, msum[WIDTH:1]};
                        lo  <= {msum[0], lo[WIDTH-1:1]};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == SHW'(WIDTH - 1)) state <= DONE;
                end
                DONE: begin
                    res      <= md_res;
                    res_zero <= (md_res == '0);
                    valid    <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    assign bus.in_ready = !valid || bus.out_ready;
    assign bus.busy     = 1'b0;

    always_ff @(posedge clock) begin
        if (reset) begin
            valid    <= 1'b0;
            res      <= '0;
            res_zero <= 1'b0;
        end else if (accept) begin
            res      <= sc_res;
            res_zero <= (sc_res == '0);
            valid    <= 1'b1;
        end else if (bus.out_ready) begin
            valid <= 1'b0;
        end
    end
`endif
endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: driver pushes expected results, monitor pops on each new output.
module tb_alu_mc;
    localparam int unsigned W = 32;

    typedef struct {
        logic [W-1:0] s;
        logic         z;
        int unsigned  cyc;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    alu_mc_if #(.WIDTH(W)) bus ();

    alu_mc #(.WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int          checks   = 0;
    int          failures = 0;
    int unsigned cyc      = 0;
    exp_t        q[$];
    bit          rand_mode = 1'b0;
    bit          ready_fix = 1'b1;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic bit is_iter(input logic [4:0] op);
`ifdef ALU_MC_MULDIV_EN
        return op[4] && (op[3:2] == 2'b00);
`else
        return 1'b0;
`endif
    endfunction

    // Reference behaviour straight from the opcode table.
    function automatic logic [W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic [4:0] op);
        logic [63:0] p;
        int          sh;
        p  = {32'b0, x} * {32'b0, y};
        sh = int'(x % W);
        if (!op[4]) begin
            casez (op[3:0])
                4'b?000: return x + y;
                4'b?100: return x - y;
                4'b?001: return x & y;
                4'b?101: return x | y;
                4'b?010: return x ^ y;
                4'b?110: return x << (W / 2);
                4'b0011: return y << sh;
                4'b0111: return y >> sh;
                4'b1111: return $unsigned($signed(y) >>> sh);
                default: return W'($countones(x ^ y));
            endcase
        end
`ifdef ALU_MC_MULDIV_EN
        case (op)
            5'b10000: return p[31:0];
            5'b10001: return p[63:32];
            5'b10010: return (y == 0) ? '1 : x / y;
            5'b10011: return (y == 0) ? x : x % y;
            default:  return '0;
        endcase
`else
        return '0;
`endif
    endfunction

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(negedge clock);
            bus.out_ready = rand_mode ? ($urandom_range(0, 3) != 0) : ready_fix;
        end
    end

    // Monitor: a new result is one that appears after an idle or handshaken cycle.
    initial begin
        exp_t cur;
        bit   pv = 1'b0;
        bit   pr = 1'b0;
        bit   have = 1'b0;
        forever begin
            @(negedge clock);
            #2;
            if (reset) begin
                pv   = 1'b0;
                pr   = 1'b0;
                have = 1'b0;
            end else begin
                if (bus.out_valid) begin
                    if (!pv || pr) begin
                        if (q.size() == 0) begin
                            checks++;
                            failures++;
                            have = 1'b0;
                            $display("FAIL unexpected_result: got s=0x%0h, required no output",
                                     bus.s);
                        end else begin
                            cur  = q.pop_front();
                            have = 1'b1;
                            chk("result_s", 64'(bus.s), 64'(cur.s));
                            chk("result_z", 64'(bus.z), 64'(cur.z));
                            chk("result_cycle", 64'(cyc), 64'(cur.cyc));
                        end
                    end else if (have) begin
                        chk("held_s", 64'(bus.s), 64'(cur.s));
                        chk("held_z", 64'(bus.z), 64'(cur.z));
                    end
                    if (!bus.out_ready) chk("in_ready_stalled", 64'(bus.in_ready), 64'(0));
                end
                pv = bus.out_valid;
                pr = bus.out_ready;
            end
        end
    end

    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic [4:0] op,
                         input bit use_exp, input logic [W-1:0] es);
        exp_t         e;
        int           n;
        logic [W-1:0] r;
        n = 0;
        @(negedge clock);
        bus.in_valid = 1'b1;
        bus.a        = ia;
        bus.b        = ib;
        bus.aluc     = op;
        #1;
        while (!bus.in_ready && n < 300) begin
            @(negedge clock);
            #1;
            n++;
        end
        if (!bus.in_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: in_ready still 0 after %0d cycles, required 1", n);
            bus.in_valid = 1'b0;
            return;
        end
        r     = use_exp ? es : model(ia, ib, op);
        e.s   = r;
        e.z   = (r == '0);
        e.cyc = cyc + 1 + (is_iter(op) ? W + 1 : 0);
        q.push_back(e);
        @(posedge clock);
    endtask

    task automatic idle();
        @(negedge clock);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 2000) begin
            @(negedge clock);
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", q.size());
            q.delete();
        end
        repeat (2) @(negedge clock);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [4:0]   rop;
        bus.in_valid = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        bus.aluc     = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
        chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_s", 64'(bus.s), 64'(0));
        chk("rst_z", 64'(bus.z), 64'(0));
        chk("rst_busy", 64'(bus.busy), 64'(0));

        issue(32'd3, 32'd5, 5'b00000, 1'b1, 32'd8);
        issue(32'd5, 32'd5, 5'b00100, 1'b1, 32'd0);
        issue(32'hFFFF0000, 32'h0000FFFF, 5'b01011, 1'b1, 32'd32);
        issue(32'd36, 32'h80000000, 5'b01111, 1'b1, 32'hF8000000);
        idle();
        drain();

`ifdef ALU_MC_MULDIV_EN
        issue(32'hFFFFFFFF, 32'hFFFFFFFF, 5'b10001, 1'b1, 32'hFFFFFFFE);
        idle();
        for (int i = 0; i < W + 4; i++) begin
            #1;
            if (bus.out_valid) break;
            chk("iter_busy", 64'(bus.busy), 64'(1));
            chk("iter_in_ready", 64'(bus.in_ready), 64'(0));
            @(negedge clock);
        end
        chk("mulhu_out_valid", 64'(bus.out_valid), 64'(1));
        drain();
        issue(32'd100, 32'd0, 5'b10010, 1'b1, 32'hFFFFFFFF);
        issue(32'd100, 32'd7, 5'b10011, 1'b1, 32'd2);
`else
        issue(32'hFFFFFFFF, 32'hFFFFFFFF, 5'b10001, 1'b1, 32'd0);
        idle();
        #1;
        chk("nomd_busy", 64'(bus.busy), 64'(0));
        issue(32'd100, 32'd0, 5'b10010, 1'b1, 32'd0);
        issue(32'd100, 32'd7, 5'b10011, 1'b1, 32'd0);
`endif
        idle();
        drain();

        // Hold a result under backpressure, then stream back-to-back.
        ready_fix = 1'b0;
        issue(32'd7, 32'd9, 5'b00000, 1'b0, '0);
        idle();
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_out_valid", 64'(bus.out_valid), 64'(1));
            chk("bp_in_ready", 64'(bus.in_ready), 64'(0));
            @(negedge clock);
        end
        ready_fix = 1'b1;
        issue(32'h0F0F0000, 32'h000000F0, 5'b00101, 1'b0, '0);
        issue(32'd3, 32'h00000001, 5'b00011, 1'b0, '0);
        issue(32'h12345678, 32'h12345678, 5'b00010, 1'b0, '0);
        idle();
        drain();

        // Reset with a result pending must drop it.
        ready_fix = 1'b0;
        issue(32'd1, 32'd1, 5'b00000, 1'b0, '0);
        idle();
        @(negedge clock);
        reset = 1'b1;
        q.delete();
        @(negedge clock);
        reset     = 1'b0;
        ready_fix = 1'b1;
        #1;
        chk("rstp_out_valid", 64'(bus.out_valid), 64'(0));
        chk("rstp_s", 64'(bus.s), 64'(0));
        chk("rstp_in_ready", 64'(bus.in_ready), 64'(1));

`ifdef ALU_MC_MULDIV_EN
        issue(32'd3, 32'd5, 5'b00000, 1'b1, 32'd8);
        issue($urandom, $urandom, 5'b10000, 1'b0, '0);
        idle();
        repeat (9) @(negedge clock);
        reset = 1'b1;
        q.delete();
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("rstm_in_ready", 64'(bus.in_ready), 64'(1));
        chk("rstm_busy", 64'(bus.busy), 64'(0));
        chk("rstm_s", 64'(bus.s), 64'(0));
        chk("rstm_z", 64'(bus.z), 64'(0));
        for (int i = 0; i < W + 5; i++) begin
            @(negedge clock);
            #1;
            chk("rstm_no_out_valid", 64'(bus.out_valid), 64'(0));
        end
`endif

        rand_mode = 1'b1;
        for (int i = 0; i < 300; i++) begin
            ra  = $urandom;
            rb  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            rop = 5'($urandom_range(0, 31));
            issue(ra, rb, rop, 1'b0, '0);
            if ($urandom_range(0, 3) == 0) begin
                idle();
                repeat ($urandom_range(0, 3)) @(negedge clock);
            end
        end
        idle();
        rand_mode = 1'b0;
        ready_fix = 1'b1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
